// File: rtl/pc_gen_pkg.sv
// Shared definitions for the pc_gen program-counter block: FSM states,
// RV32I branch funct3 codes and default reset/trap vectors.
// Optional compressed-instruction support is selected with PC_GEN_RVC_EN.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } state_t;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   localparam int          DEFAULT_XLEN      = 32;
   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle of decode-side controls and fetch-side outputs of pc_gen.
// The master modport is the pc_gen view; slave is the decode/fetch view.
// With PC_GEN_RVC_EN defined an instr_half signal is added.
interface pc_gen_if #(
   parameter int XLEN = 32
);

`ifdef PC_GEN_RVC_EN
   logic            instr_half;
`endif
   logic            stall;
   logic            fetch_ready;
   logic            instr_valid;
   logic            branch;
   logic            jump;
   logic            jalr;
   logic [2:0]      branch_op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus;
   logic            fetch_valid;
   logic            misaligned;
   logic [XLEN-1:0] bad_addr;

   modport master (
`ifdef PC_GEN_RVC_EN
      input  instr_half,
`endif
      input  stall,
      input  fetch_ready,
      input  instr_valid,
      input  branch,
      input  jump,
      input  jalr,
      input  branch_op,
      input  rs1_data,
      input  rs2_data,
      input  imm,
      output pc,
      output pc_plus,
      output fetch_valid,
      output misaligned,
      output bad_addr
   );

   modport slave (
`ifdef PC_GEN_RVC_EN
      output instr_half,
`endif
      output stall,
      output fetch_ready,
      output instr_valid,
      output branch,
      output jump,
      output jalr,
      output branch_op,
      output rs1_data,
      output rs2_data,
      output imm,
      input  pc,
      input  pc_plus,
      input  fetch_valid,
      input  misaligned,
      input  bad_addr
   );

endinterface

// File: rtl/branch_cmp.sv
// Combinational RV32I branch condition evaluator. Kept standalone so the
// pipelined execute stage can reuse it unchanged.
module branch_cmp
   import pc_gen_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      branch_op,
   output logic            taken
);

   // Decode funct3 into a taken decision; reserved codes are never taken
   always_comb begin
      taken = 1'b0;
      case (branch_op)
         BEQ:     taken = (rs1 == rs2);
         BNE:     taken = (rs1 != rs2);
         BLT:     taken = ($signed(rs1) <  $signed(rs2));
         BGE:     taken = ($signed(rs1) >= $signed(rs2));
         BLTU:    taken = (rs1 <  rs2);
         BGEU:    taken = (rs1 >= rs2);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator for the RV32I core: picks sequential, branch,
// jal or jalr next-PC, holds on stall or when fetch is not ready, and
// redirects misaligned control-flow targets to a trap vector.
// Define PC_GEN_RVC_EN for 16-bit instruction support (2-byte step,
// only bit0 checked for alignment).
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = DEFAULT_XLEN,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEFAULT_TRAP_VEC)
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.master bus
);

   state_t          state;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] bad_q;
   logic            fv_q;
   logic            mis_q;

   logic            taken;
   logic [XLEN-1:0] step;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] rel_target;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_target;
   logic [XLEN-1:0] target;
   logic            use_jalr;
   logic            use_jump;
   logic            use_branch;
   logic            redirect;
   logic            bad_align;
   logic            adv;

   branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
      .rs1       (bus.rs1_data),
      .rs2       (bus.rs2_data),
      .branch_op (bus.branch_op),
      .taken     (taken)
   );

   // Sequential step size: 2 for a compressed instruction, otherwise 4
   always_comb begin
      step = XLEN'(4);
`ifdef PC_GEN_RVC_EN
      if (bus.instr_half) begin
         step = XLEN'(2);
      end
`endif
   end

   // Next-PC selection with jalr > jal > taken branch > sequential priority
   always_comb begin
      use_jalr    = bus.instr_valid & bus.jalr;
      use_jump    = bus.instr_valid & bus.jump;
      use_branch  = bus.instr_valid & bus.branch & taken;
      redirect    = use_jalr | use_jump | use_branch;
      seq_pc      = pc_q + step;
      rel_target  = pc_q + bus.imm;
      jalr_sum    = bus.rs1_data + bus.imm;
      jalr_target = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
      if (use_jalr) begin
         target = jalr_target;
      end else if (use_jump | use_branch) begin
         target = rel_target;
      end else begin
         target = seq_pc;
      end
`ifdef PC_GEN_RVC_EN
      bad_align = redirect & target[0];
`else
      bad_align = redirect & target[1];
`endif
      adv = (state == RUN) & bus.fetch_ready & ~bus.stall;
   end

   // Fetch FSM: one idle cycle after reset and after a trap, then run
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
         pc_q  <= RESET_VEC;
         bad_q <= '0;
         fv_q  <= 1'b0;
         mis_q <= 1'b0;
      end else begin
         mis_q <= 1'b0;
         case (state)
            BOOT: begin
               state <= RUN;
               fv_q  <= 1'b1;
            end
            RUN: begin
               if (adv) begin
                  if (bad_align) begin
                     state <= TRAP;
                     pc_q  <= TRAP_VEC;
                     bad_q <= target;
                     mis_q <= 1'b1;
                     fv_q  <= 1'b0;
                  end else begin
                     pc_q  <= target;
                  end
               end
            end
            TRAP: begin
               state <= RUN;
               fv_q  <= 1'b1;
            end
            default: begin
               state <= BOOT;
               fv_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pc_plus     = seq_pc;
   assign bus.fetch_valid = fv_q;
   assign bus.misaligned  = mis_q;
   assign bus.bad_addr    = bad_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a behavioural next-PC model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
// Honours PC_GEN_RVC_EN when the design is built with it.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_GEN_RVC_EN
   localparam bit          RVC = 1'b1;
`else
   localparam bit          RVC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   int n_cmp = 0;
   int n_bad = 0;

   pc_gen_if #(.XLEN(32)) bus ();

   pc_gen #(
      .XLEN      (32),
      .RESET_VEC (RV),
      .TRAP_VEC  (TV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Shared comparison helper used by the model checker and directed checks
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model state
   logic [31:0] m_pc;
   logic [31:0] m_bad;
   logic        m_fv;
   logic        m_mis;
   bit          m_ok = 1'b0;
   logic [31:0] m_tgt;
   bit          m_redir;

   function automatic logic [31:0] stepSize();
`ifdef PC_GEN_RVC_EN
      return bus.instr_half ? 32'd2 : 32'd4;
`else
      return 32'd4;
`endif
   endfunction

   function automatic bit condHolds(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int signed sa;
      int signed sb;
      sa = a;
      sb = b;
      case (op)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return sa < sb;
         3'd5:    return sa >= sb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Model: fetch is idle one cycle after reset or trap, otherwise advances
   always @(posedge clk) begin
      if (rst) begin
         m_pc  = RV;
         m_bad = 32'h0;
         m_fv  = 1'b0;
         m_mis = 1'b0;
         m_ok  = 1'b1;
      end else if (m_ok) begin
         m_mis = 1'b0;
         if (!m_fv) begin
            m_fv = 1'b1;
         end else if (bus.fetch_ready && !bus.stall) begin
            m_redir = 1'b1;
            if (bus.instr_valid && bus.jalr) begin
               m_tgt = (bus.rs1_data + bus.imm) & 32'hFFFF_FFFE;
            end else if (bus.instr_valid && bus.jump) begin
               m_tgt = m_pc + bus.imm;
            end else if (bus.instr_valid && bus.branch && condHolds(bus.branch_op, bus.rs1_data, bus.rs2_data)) begin
               m_tgt = m_pc + bus.imm;
            end else begin
               m_tgt   = m_pc + stepSize();
               m_redir = 1'b0;
            end
            if (m_redir && (RVC ? m_tgt[0] : m_tgt[1])) begin
               m_bad = m_tgt;
               m_mis = 1'b1;
               m_fv  = 1'b0;
               m_pc  = TV;
            end else begin
               m_pc = m_tgt;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (m_ok) begin
         checkOutput("model_pc", bus.pc, m_pc);
         checkOutput("model_pc_plus", bus.pc_plus, m_pc + stepSize());
         checkOutput("model_fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, m_fv});
         checkOutput("model_misaligned", {31'b0, bus.misaligned}, {31'b0, m_mis});
         checkOutput("model_bad_addr", bus.bad_addr, m_bad);
      end
   end

   task automatic applyStimulus(input logic iv, input logic br, input logic jp, input logic jr,
                                input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] im);
      bus.instr_valid = iv;
      bus.branch      = br;
      bus.jump        = jp;
      bus.jalr        = jr;
      bus.branch_op   = op;
      bus.rs1_data    = a;
      bus.rs2_data    = b;
      bus.imm         = im;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [31:0] trap_imm;
   logic [31:0] odd_imm;

   initial begin
      trap_imm = RVC ? 32'h7 : 32'h6;
      odd_imm  = RVC ? 32'h1 : 32'h2;
      rst             = 1'b1;
      bus.stall       = 1'b0;
      bus.fetch_ready = 1'b1;
`ifdef PC_GEN_RVC_EN
      bus.instr_half  = 1'b0;
`endif
      applyStimulus(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      tick(2);
      checkOutput("reset_pc", bus.pc, 32'h0);
      checkOutput("reset_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
      checkOutput("reset_misaligned", {31'b0, bus.misaligned}, 32'h0);
      checkOutput("reset_bad_addr", bus.bad_addr, 32'h0);

      rst = 1'b0;
      tick(1);
      checkOutput("boot_pc", bus.pc, 32'h0);
      checkOutput("boot_fetch_valid", {31'b0, bus.fetch_valid}, 32'h1);
      tick(1);
      checkOutput("seq_pc4", bus.pc, 32'h4);
      tick(1);
      checkOutput("seq_pc8", bus.pc, 32'h8);

      applyStimulus(1, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h38);
      tick(1);
      checkOutput("jal_to_40", bus.pc, 32'h40);
      applyStimulus(1, 1, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h10);
      tick(1);
      checkOutput("bge_not_taken", bus.pc, 32'h44);
      applyStimulus(1, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC);
      tick(1);
      checkOutput("jal_back", bus.pc, 32'h40);
      applyStimulus(1, 1, 0, 0, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h10);
      tick(1);
      checkOutput("bgeu_taken", bus.pc, 32'h50);
      applyStimulus(0, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h100);
      tick(1);
      checkOutput("invalid_ignored", bus.pc, 32'h54);
      applyStimulus(1, 1, 0, 0, 3'b010, 32'h5, 32'h5, 32'h8);
      tick(1);
      checkOutput("op010_never", bus.pc, 32'h58);

      for (int op = 0; op < 8; op++) begin
         applyStimulus(1, 1, 0, 0, 3'(op), 32'h5, 32'h5, 32'h8);
         tick(1);
         applyStimulus(1, 1, 0, 0, 3'(op), 32'h8000_0000, 32'h1, 32'h8);
         tick(1);
         applyStimulus(1, 1, 0, 0, 3'(op), 32'h1, 32'h8000_0000, 32'hFFFF_FFF8);
         tick(1);
      end

      applyStimulus(1, 0, 0, 1, 3'd0, 32'h1001, 32'h0, 32'h0);
      tick(1);
      checkOutput("jalr_mask", bus.pc, 32'h1000);
      checkOutput("jalr_no_trap", {31'b0, bus.misaligned}, 32'h0);
      applyStimulus(1, 1, 1, 1, 3'd0, 32'h200, 32'h200, 32'h8);
      tick(1);
      checkOutput("priority_jalr", bus.pc, 32'h208);

      applyStimulus(1, 0, 0, 1, 3'd0, 32'h20, 32'h0, 32'h0);
      tick(1);
      applyStimulus(1, 0, 1, 0, 3'd0, 32'h0, 32'h0, trap_imm);
      tick(1);
      checkOutput("trap_pc", bus.pc, TV);
      checkOutput("trap_bad_addr", bus.bad_addr, 32'h20 + trap_imm);
      checkOutput("trap_pulse", {31'b0, bus.misaligned}, 32'h1);
      checkOutput("trap_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
      applyStimulus(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      tick(1);
      checkOutput("trap_end_pc", bus.pc, TV);
      checkOutput("trap_pulse_once", {31'b0, bus.misaligned}, 32'h0);
      checkOutput("trap_end_valid", {31'b0, bus.fetch_valid}, 32'h1);
      tick(1);
      checkOutput("after_trap_seq", bus.pc, 32'h104);

      applyStimulus(1, 0, 0, 1, 3'd0, 32'h80, 32'h0, 32'h0);
      tick(1);
      bus.stall = 1'b1;
      applyStimulus(1, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h20);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checkOutput("stall_hold", bus.pc, 32'h80);
      end
      bus.stall = 1'b0;
      tick(1);
      checkOutput("stall_release", bus.pc, 32'hA0);

      applyStimulus(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      bus.fetch_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick(1);
         checkOutput("not_ready_hold", bus.pc, 32'hA0);
         checkOutput("not_ready_valid", {31'b0, bus.fetch_valid}, 32'h1);
      end
      bus.fetch_ready = 1'b1;
      tick(1);
      checkOutput("ready_resume", bus.pc, 32'hA4);

      applyStimulus(1, 0, 1, 0, 3'd0, 32'h0, 32'h0, odd_imm);
      tick(1);
      checkOutput("trap2_pulse", {31'b0, bus.misaligned}, 32'h1);
      checkOutput("trap2_bad_addr", bus.bad_addr, 32'hA4 + odd_imm);
      rst       = 1'b1;
      bus.stall = 1'b1;
      tick(1);
      checkOutput("rst_in_trap_pc", bus.pc, RV);
      checkOutput("rst_in_trap_mis", {31'b0, bus.misaligned}, 32'h0);
      checkOutput("rst_in_trap_valid", {31'b0, bus.fetch_valid}, 32'h0);
      checkOutput("rst_in_trap_bad", bus.bad_addr, 32'h0);
      rst       = 1'b0;
      bus.stall = 1'b0;
      applyStimulus(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      tick(1);
      checkOutput("reboot_valid", {31'b0, bus.fetch_valid}, 32'h1);

      applyStimulus(1, 0, 0, 1, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0);
      tick(1);
      applyStimulus(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      tick(1);
      checkOutput("wrap_to_zero", bus.pc, 32'h0);

`ifdef PC_GEN_RVC_EN
      applyStimulus(1, 0, 0, 1, 3'd0, 32'h10, 32'h0, 32'h0);
      tick(1);
      applyStimulus(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      bus.instr_half = 1'b1;
      #1;
      checkOutput("rvc_pc_plus", bus.pc_plus, 32'h12);
      tick(1);
      checkOutput("rvc_half_step", bus.pc, 32'h12);
      bus.instr_half = 1'b0;
      applyStimulus(1, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h2);
      tick(1);
      checkOutput("rvc_jal_even2", bus.pc, 32'h14);
      checkOutput("rvc_no_trap", {31'b0, bus.misaligned}, 32'h0);
`endif

      applyStimulus(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter for the RV32I core.
- Selects the next PC from sequential, branch, jal and jalr sources.
- Evaluates all six RV32I branch conditions internally, so the ALU zero flag is no longer needed.
- Adds a fetch handshake and stall hold, a configurable reset vector, and detection of misaligned control-flow targets with redirect to a trap vector. Sits between decode/register-file outputs and instruction memory.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hazard hold; PC frozen while high.
- fetch_ready  input  1  instruction memory accepts the current pc.
- instr_valid  input  1  decode controls below are valid this cycle.
- branch  input  1  conditional branch instruction.
- jump  input  1  jal.
- jalr  input  1  jalr.
- branch_op  input  3  funct3 of the branch.
- rs1_data  input  XLEN  register operand 1.
- rs2_data  input  XLEN  register operand 2.
- imm  input  XLEN  sign-extended immediate.
- pc  output  XLEN  current fetch address.
- pc_plus  output  XLEN  link value: pc+4, or pc+2/pc+4 under RVC.
- fetch_valid  output  1  pc presented to instruction memory is valid.
- misaligned  output  1  one-cycle pulse: trap taken.
- bad_addr  output  XLEN  offending target, held until the next trap.

Behaviour:
- All sequential logic: always_ff @(posedge clk); `if (rst)` is the first branch. Reset is synchronous and active-high.
- Reset values:
  - pc = RESET_VEC; bad_addr = 0; misaligned = 0; fetch_valid = 0.
  - state = BOOT.
- States:
  - BOOT: fetch_valid = 0. Next state is RUN unconditionally; pc is unchanged.
  - RUN: fetch_valid = 1.
  - TRAP: fetch_valid = 0, pc = TRAP_VEC. Next state is RUN after 1 cycle.
- adv = (state==RUN) & fetch_ready & ~stall. pc updates only when adv=1; otherwise pc, state and bad_addr hold. A stall in BOOT or TRAP does not delay the transition to RUN.
- Branch condition by branch_op:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011: never taken.
- Controls are ignored when instr_valid=0.
- Target priority when adv=1:
  1. jalr: target = (rs1_data + imm) & ~1.
  2. jump: target = pc + imm.
  3. branch taken: target = pc + imm.
  4. Otherwise: pc + 4 (sequential; never traps).
- If more than one of jalr/jump/branch is asserted, the highest priority wins.
- Arithmetic is modulo 2^XLEN. Wrap from all-ones+4 to 0 is legal and silent.
- Misaligned redirect (target[1]==1 without RVC; never with RVC after jalr masking, since bit0 is already cleared and jal/branch imm is even):
  - pc <= TRAP_VEC, bad_addr <= target, misaligned <= 1 for one cycle, state <= TRAP.
- Reset asserted in any state, including mid-trap or under stall, returns to BOOT with all reset values on the next edge.
- pc_plus is combinational from pc.

Optional Feature:
- Macro: PC_GEN_RVC_EN.
- Defined:
  - Adds input `instr_half` (1 = 16-bit instruction).
  - Sequential step and pc_plus are pc+2 when instr_half=1, else pc+4.
  - Alignment check requires only bit0 = 0.
- Undefined:
  - No instr_half port; step is always 4.
  - Any target with bit1 set traps.

Decomposition:
- Package pc_gen_pkg:
  - state enum {BOOT, RUN, TRAP}.
  - branch funct3 localparams BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Default RESET_VEC and TRAP_VEC constants.
- One sub-module, branch_cmp: purely combinational (rs1, rs2, branch_op) -> taken. Reused later by the pipelined execute stage.

Test Plan:
- Reset release, fetch_ready=1 → cycle 0: pc=0, fetch_valid=0; then pc 0→4→8 on successive edges.
- pc=0x40, branch=1, op=101, rs1=0xFFFFFFFF, rs2=1 → not taken (signed -1<1), pc=0x44. Same with op=111 → taken, imm=0x10 gives pc=0x50.
- jalr with rs1=0x1001, imm=0x0 → pc=0x1000, no trap. jump with imm=0x6 at pc=0x20 (no RVC) → pc=0x100, bad_addr=0x26, misaligned pulses once, fetch_valid low 1 cycle, then pc=0x104.
- stall=1 for 3 cycles with jump asserted at pc=0x80 → pc holds 0x80. After release → pc=0x80+imm.
- fetch_ready=0 for 2 cycles → pc holds and fetch_valid stays 1. rst asserted during TRAP → next edge pc=RESET_VEC, state BOOT, misaligned=0.
- PC_GEN_RVC_EN: instr_half=1 at pc=0x10 → pc=0x12, pc_plus=0x12. jump imm=0x2 → pc=0x14, no trap.
